// File: rtl/lc2k_reg_file_pkg.sv
// LC2K register file shared types and sizes.
// Used by the register file top, its bus interface and the dump sequencer.
package lc2k_pkg;
   localparam int REG_IDX_W = 3;
   localparam int DATA_W    = 32;
   localparam int NUM_REGS  = 8;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0]    data_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DUMP = 2'd1,
      DONE = 2'd2
   } rf_dump_state_t;
endpackage

// File: rtl/lc2k_reg_file_if.sv
// Register file bus: read ports, write path, halt and dump outputs.
// master drives requests, slave is the register file.
interface lc2k_reg_file_if;
   import lc2k_pkg::*;

   reg_idx_t regA;
   reg_idx_t regB;
   reg_idx_t write_reg;
   data_t    write_data;
   logic     CONTROL_REG_WRITE;
   logic     halt;
   data_t    readA;
   data_t    readB;
   logic     dump_valid;
   reg_idx_t dump_idx;
   data_t    dump_data;
   logic     dump_done;

   modport master (
      output regA, regB, write_reg, write_data,
      output CONTROL_REG_WRITE, halt,
      input  readA, readB,
      input  dump_valid, dump_idx, dump_data, dump_done
   );

   modport slave (
      input  regA, regB, write_reg, write_data,
      input  CONTROL_REG_WRITE, halt,
      output readA, readB,
      output dump_valid, dump_idx, dump_data, dump_done
   );
endinterface

// File: rtl/lc2k_rf_dump_seq.sv
// Post-halt dump sequencer: walks r0..r7 once, then latches done.
// Reads the array through o_rd_idx / i_rd_data; all outputs registered.
module lc2k_rf_dump_seq
   import lc2k_pkg::*;
(
   input  logic     i_clk,
   input  logic     i_rst,
   input  logic     i_halt,
   output reg_idx_t o_rd_idx,
   input  data_t    i_rd_data,
   output logic     o_dump_valid,
   output reg_idx_t o_dump_idx,
   output data_t    o_dump_data,
   output logic     o_dump_done
);

   rf_dump_state_t r_state;
   reg_idx_t       r_cnt;
   logic           r_valid;
   reg_idx_t       r_idx;
   data_t          r_data;
   logic           r_done;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_idx   <= '0;
         r_data  <= '0;
         r_done  <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_valid <= 1'b0;
               if (i_halt) begin
                  r_state <= DUMP;
                  r_cnt   <= '0;
               end
            end
            DUMP: begin
               // Entry reflects the array as it stands at this edge
               r_valid <= 1'b1;
               r_idx   <= r_cnt;
               r_data  <= i_rd_data;
               r_cnt   <= r_cnt + reg_idx_t'(1);
               if (r_cnt == reg_idx_t'(NUM_REGS - 1))
                  r_state <= DONE;
            end
            DONE: begin
               r_valid <= 1'b0;
               r_done  <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_rd_idx     = r_cnt;
   assign o_dump_valid = r_valid;
   assign o_dump_idx   = r_idx;
   assign o_dump_data  = r_data;
   assign o_dump_done  = r_done;

endmodule

// File: rtl/lc2k_reg_file.sv
// LC2K architectural register file, 8 x 32, r0 hardwired to zero.
// Define LC2K_RF_BYPASS_EN to forward same-cycle writes to the read ports.
module lc2k_reg_file
   import lc2k_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   lc2k_reg_file_if.slave     bus
);

   data_t    r_regs [NUM_REGS];
   data_t    r_wd_q;
   logic     r_we_q;
   logic     w_wr_en;
   reg_idx_t w_dump_rd_idx;
   data_t    w_dump_rd_data;

   // Data/enable lead the index by one cycle; delay them to line up
   assign w_wr_en = r_we_q && (bus.write_reg != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            r_regs[i] <= '0;
         r_wd_q <= '0;
         r_we_q <= 1'b0;
      end else begin
         r_wd_q <= bus.write_data;
         r_we_q <= bus.CONTROL_REG_WRITE;
         if (w_wr_en)
            r_regs[bus.write_reg] <= r_wd_q;
      end
   end

`ifdef LC2K_RF_BYPASS_EN
   assign bus.readA = (w_wr_en && bus.regA == bus.write_reg) ?
                      r_wd_q : r_regs[bus.regA];
   assign bus.readB = (w_wr_en && bus.regB == bus.write_reg) ?
                      r_wd_q : r_regs[bus.regB];
`else
   assign bus.readA = r_regs[bus.regA];
   assign bus.readB = r_regs[bus.regB];
`endif

   assign w_dump_rd_data = r_regs[w_dump_rd_idx];

   lc2k_rf_dump_seq u_dump (
      .i_clk        (clk),
      .i_rst        (reset),
      .i_halt       (bus.halt),
      .o_rd_idx     (w_dump_rd_idx),
      .i_rd_data    (w_dump_rd_data),
      .o_dump_valid (bus.dump_valid),
      .o_dump_idx   (bus.dump_idx),
      .o_dump_data  (bus.dump_data),
      .o_dump_done  (bus.dump_done)
   );

endmodule

// File: tb/tb_lc2k_reg_file.sv
// Directed bench for lc2k_reg_file: writes, r0, reads, dump and reset.
// Inputs change 1ns after the rising edge; outputs checked 3ns after it.
module tb_lc2k_reg_file;
   import lc2k_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   logic found;

   lc2k_reg_file_if bus ();

   lc2k_reg_file dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Data/enable one cycle, matching index the next cycle
   task automatic wr(input reg_idx_t idx, input data_t val);
      bus.write_data        = val;
      bus.CONTROL_REG_WRITE = 1'b1;
      step();
      bus.write_reg         = idx;
      bus.write_data        = '0;
      bus.CONTROL_REG_WRITE = 1'b0;
      step();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      found    = 1'b0;
      reset    = 1'b1;
      bus.regA = '0;
      bus.regB = '0;
      bus.write_reg = '0;
      bus.write_data = '0;
      bus.CONTROL_REG_WRITE = 1'b0;
      bus.halt = 1'b0;
      step();
      step();
      reset = 1'b0;

      bus.regA = 3'd3;
      bus.regB = 3'd7;
      settle();
      check("rst_readA", bus.readA, 32'h0);
      check("rst_readB", bus.readB, 32'h0);
      check("rst_done", {31'b0, bus.dump_done}, 32'h0);
      check("rst_valid", {31'b0, bus.dump_valid}, 32'h0);

      step();
      bus.write_data = 32'h0000_1234;
      bus.CONTROL_REG_WRITE = 1'b1;
      step();
      bus.write_data = '0;
      bus.CONTROL_REG_WRITE = 1'b0;
      bus.write_reg = 3'd5;
      bus.regA = 3'd5;
      settle();
`ifdef LC2K_RF_BYPASS_EN
      check("align_c1", bus.readA, 32'h0000_1234);
`else
      check("align_c1", bus.readA, 32'h0);
`endif
      step();
      settle();
      check("align_c2", bus.readA, 32'h0000_1234);
      check("align_rdB", bus.readB, 32'h0);

      bus.regA = 3'd0;
      bus.write_data = 32'hFFFF_FFFF;
      bus.CONTROL_REG_WRITE = 1'b1;
      step();
      bus.write_reg = 3'd0;
      bus.write_data = '0;
      bus.CONTROL_REG_WRITE = 1'b0;
      settle();
      check("r0_same", bus.readA, 32'h0);
      step();
      settle();
      check("r0_after", bus.readA, 32'h0);

      bus.regA = 3'd2;
      bus.write_data = 32'h0000_DEAD;
      bus.CONTROL_REG_WRITE = 1'b0;
      step();
      bus.write_reg = 3'd2;
      bus.write_data = '0;
      step();
      step();
      settle();
      check("we_off_r2", bus.readA, 32'h0);

      for (int i = 1; i < 7; i++)
         wr(reg_idx_t'(i), data_t'(i));
      bus.regA = 3'd6;
      bus.regB = 3'd1;
      settle();
      check("load_r6", bus.readA, 32'h6);
      check("load_r1", bus.readB, 32'h1);

      // r7 write lands on the same edge that starts the dump
      bus.write_data = 32'h7;
      bus.CONTROL_REG_WRITE = 1'b1;
      step();
      bus.write_data = '0;
      bus.CONTROL_REG_WRITE = 1'b0;
      bus.write_reg = 3'd7;
      bus.halt = 1'b1;
      step();
      bus.halt = 1'b0;
      bus.write_reg = 3'd0;
      for (int i = 0; i < 8; i++) begin
         bus.halt = (i == 3);
         step();
         settle();
         check($sformatf("dump_v%0d", i),
               {31'b0, bus.dump_valid}, 32'h1);
         check($sformatf("dump_i%0d", i),
               {29'b0, bus.dump_idx}, i);
         check($sformatf("dump_d%0d", i), bus.dump_data, i);
      end
      bus.halt = 1'b0;
      step();
      settle();
      check("done_valid", {31'b0, bus.dump_valid}, 32'h0);
      check("done_flag", {31'b0, bus.dump_done}, 32'h1);

      bus.halt = 1'b1;
      step();
      bus.halt = 1'b0;
      step();
      step();
      settle();
      check("halt2_valid", {31'b0, bus.dump_valid}, 32'h0);
      check("halt2_done", {31'b0, bus.dump_done}, 32'h1);

      reset = 1'b1;
      step();
      reset = 1'b0;
      settle();
      check("rst2_done", {31'b0, bus.dump_done}, 32'h0);
      wr(3'd3, 32'h33);
      bus.halt = 1'b1;
      step();
      bus.halt = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         step();
         settle();
         if (bus.dump_valid && bus.dump_idx == 3'd3)
            found = 1'b1;
      end
      check("mid_found", {31'b0, found}, 32'h1);
      check("mid_d3", bus.dump_data, 32'h33);

      reset = 1'b1;
      step();
      settle();
      bus.regA = 3'd3;
      bus.regB = 3'd7;
      #1;
      check("mid_rst_valid", {31'b0, bus.dump_valid}, 32'h0);
      check("mid_rst_idx", {29'b0, bus.dump_idx}, 32'h0);
      check("mid_rst_data", bus.dump_data, 32'h0);
      check("mid_rst_r3", bus.readA, 32'h0);
      check("mid_rst_r7", bus.readB, 32'h0);
      reset = 1'b0;
      step();
      step();
      step();
      settle();
      check("idle_valid", {31'b0, bus.dump_valid}, 32'h0);
      check("idle_done", {31'b0, bus.dump_done}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lc2k_reg_file.md
Name: lc2k_reg_file

Overview:
- Architectural register file of the LC2K CPU: 8 x 32-bit registers.
- Sits directly downstream of the write-register select stage and consumes its registered 3-bit write_reg index.
- Write data and write enable arrive one cycle earlier than the index, so the block delays them one stage internally to line up with the index.
- Provides two combinational read ports and a post-halt register dump sequencer for the testbench and debug.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 8, register count; index width = 3.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- regA  input  3  read port A index.
- regB  input  3  read port B index.
- write_reg  input  3  registered destination index from the write-select stage.
- write_data  input  DATA_W  write value, presented one cycle before its matching write_reg.
- CONTROL_REG_WRITE  input  1  write enable, presented in the same cycle as write_data.
- halt  input  1  single-cycle pulse; starts the dump.
- readA  output  DATA_W  contents of register regA.
- readB  output  DATA_W  contents of register regB.
- dump_valid  output  1  high while dump_idx/dump_data are valid.
- dump_idx  output  3  index being dumped.
- dump_data  output  DATA_W  value of register dump_idx.
- dump_done  output  1  sticky; set after the last register is dumped.

Behaviour:
- Reset (synchronous, active-high):
  - All registers, including r0, are cleared to 0.
  - The delay stage (wd_q, we_q) is cleared to 0.
  - FSM goes to IDLE; dump_valid=0, dump_idx=0, dump_data=0, dump_done=0.
  - Reset has priority over everything, including a dump in progress.
- Write alignment:
  - Cycle N: the block captures wd_q<=write_data and we_q<=CONTROL_REG_WRITE.
  - Cycle N+1: if we_q=1 and write_reg!=0, then reg[write_reg]<=wd_q at the N+1 edge.
  - Write latency from write_data to the architectural update is 2 edges.
- r0 is hardwired: writes with write_reg=0 are dropped and r0 always reads 0.
- Reads:
  - readA=reg[regA] and readB=reg[regB], combinational (no forwarding unless the optional feature below is compiled in).
  - A read in the same cycle as a write to that index returns the old value.
- Dump FSM, states IDLE, DUMP, DONE:
  - IDLE: halt=1 moves to DUMP with dump_idx=0.
  - DUMP: dump_valid=1 and dump_data=reg[dump_idx], registered output (1-cycle latency from the index increment). dump_idx increments each cycle. After index 7 is presented, go to DONE.
  - DONE: dump_valid=0, dump_done=1, held until reset. Further halt pulses are ignored.
  - halt asserted while in DUMP is ignored.
  - Writes during DUMP are still performed. A dump entry reflects register contents at the edge it is sampled.
- Simultaneous halt and pending write (we_q=1): the write completes and the dump sees the updated value on a later entry.

Optional Feature:
- Macro: LC2K_RF_BYPASS_EN.
- Defined:
  - If we_q=1, write_reg!=0 and regA==write_reg, then readA=wd_q (same rule for readB).
  - A same-cycle write is therefore visible to reads.
- Undefined: reads return stored values only, with no forwarding path.

Decomposition:
- Shared package lc2k_pkg holds:
  - REG_IDX_W=3, DATA_W=32, NUM_REGS=8.
  - Typedef reg_idx_t.
  - Dump FSM state enum rf_dump_state_t {IDLE, DUMP, DONE}.
- One natural sub-module: lc2k_rf_dump_seq, containing the FSM and the dump counter. It reads through a dedicated index port.
- The storage array and delay stage stay in the top module.

Test Plan:
- Reset then read: after reset, regA=3 and regB=7 -> readA=0 and readB=0; dump_done=0.
- Aligned write:
  - Cycle 0: write_data=0x0000_1234, CONTROL_REG_WRITE=1.
  - Cycle 1: write_reg=5, then regA=5.
  - Result: readA=0x1234 from cycle 2 onward (at cycle 1 only when LC2K_RF_BYPASS_EN is defined).
- r0 protection: write 0xFFFF_FFFF with write_reg=0 -> readA (regA=0) stays 0.
- Write disabled: CONTROL_REG_WRITE=0 with write_data=0xDEAD, write_reg=2 -> reg2 unchanged (0).
- Dump:
  - Setup: load r1..r7 = 1..7, then pulse halt.
  - Result: 8 consecutive dump_valid cycles with (idx,data)=(0,0),(1,1)..(7,7); then dump_done=1 and dump_valid=0.
  - A second halt has no effect.
- Reset mid-dump: assert reset when dump_idx=3 -> next cycle dump_valid=0, dump_idx=0, all registers=0, FSM in IDLE.
